// File: rtl/mips_pkg.sv
// mips_pkg: shared PC sequencer state encoding and default address constants.
// Revision 1.0
`default_nettype none

package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_ADDR  = 32'h0000_0080;
  localparam int          INSTR_BYTES        = 4;

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection with misaligned register-jump detect.
// Revision 1.0
`default_nettype none

module pc_next_calc #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] TRAP_ADDR  = 32'h0000_0080,
  parameter int          INCR       = 4
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  branch_taken,
  input  logic [15:0]           branch_imm,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  input  logic                  jr,
  input  logic [ADDR_WIDTH-1:0] jr_addr,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  misaligned
);

  localparam logic [ADDR_WIDTH-1:0] INCR_W = ADDR_WIDTH'(INCR);
  localparam logic [ADDR_WIDTH-1:0] TRAP_W = TRAP_ADDR[ADDR_WIDTH-1:0];

  logic [ADDR_WIDTH-1:0] jump_target;
  logic [ADDR_WIDTH-1:0] branch_off;

  assign pc_plus4   = pc + INCR_W;
  assign branch_off = {{(ADDR_WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
  assign misaligned = jr & (jr_addr[1:0] != 2'b00);

  // A 28-bit PC is fully covered by the J-type field, so no region bits remain.
  if (ADDR_WIDTH > 28) begin : g_jump_region
    assign jump_target = {pc_plus4[ADDR_WIDTH-1:28], jump_index, 2'b00};
  end else begin : g_jump_flat
    assign jump_target = {jump_index, 2'b00};
  end

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = misaligned ? TRAP_W : jr_addr;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address register with BOOT/RUN/HALT sequencing and jr trap.
// Revision 1.0
`default_nettype none

module pc_sequencer
  import mips_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
  parameter logic [31:0] TRAP_ADDR  = DEFAULT_TRAP_ADDR,
  parameter int          INCR       = INSTR_BYTES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [15:0]           branch_imm,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  input  logic                  jr,
  input  logic [ADDR_WIDTH-1:0] jr_addr,
  input  logic                  halt,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  fetch_valid,
  output logic                  halted,
  output logic                  trap,
  output logic [ADDR_WIDTH-1:0] epc
);

  pc_state_t             state;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  misaligned;

  pc_next_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TRAP_ADDR  (TRAP_ADDR),
    .INCR       (INCR)
  ) u_next (
    .pc           (pc),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_ADDR[ADDR_WIDTH-1:0];
      epc         <= '0;
      trap        <= 1'b0;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      trap <= 1'b0;
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          // Stall freezes everything; upstream re-presents the request later.
          if (!stall) begin
            pc <= next_pc;
            if (misaligned) begin
              trap <= 1'b1;
              epc  <= jr_addr;
            end
            if (halt) begin
              state       <= HALT;
              fetch_valid <= 1'b0;
              halted      <= 1'b1;
            end
          end
        end
        HALT: begin
          if (resume) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a queue-based scoreboard on 32- and 28-bit instances.
// Revision 1.0
`default_nettype none

module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_imm = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_addr = '0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;

  logic [31:0] pc, pc_plus4, epc;
  logic        fetch_valid, halted, trap;
  logic [27:0] jr_addr28, pc28, pc_plus4_28, epc28;
  logic        fetch_valid28, halted28, trap28;

  assign jr_addr28 = jr_addr[27:0];

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        h;
    logic        tr;
    logic [31:0] epc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  pc_sequencer #(.ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .jump_index(jump_index), .jr(jr),
    .jr_addr(jr_addr), .halt(halt), .resume(resume), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .halted(halted), .trap(trap), .epc(epc)
  );

  pc_sequencer #(.ADDR_WIDTH(28)) dut28 (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .jump_index(jump_index), .jr(jr),
    .jr_addr(jr_addr28), .halt(halt), .resume(resume), .pc(pc28), .pc_plus4(pc_plus4_28),
    .fetch_valid(fetch_valid28), .halted(halted28), .trap(trap28), .epc(epc28)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_next(input logic [31:0] epc_pc, input logic fv, input logic h,
                             input logic tr, input logic [31:0] e_epc);
    exp_t e;
    e.pc = epc_pc; e.fv = fv; e.h = h; e.tr = tr; e.epc = e_epc;
    q.push_back(e);
  endtask

  // One cycle: drive inputs at the falling edge, record what the next rising edge must produce.
  task automatic step(input logic st, input logic br, input logic [15:0] imm,
                      input logic jmp, input logic [25:0] idx,
                      input logic j, input logic [31:0] ja,
                      input logic hl, input logic rs,
                      input logic [31:0] e_pc, input logic e_fv, input logic e_h,
                      input logic e_tr, input logic [31:0] e_epc);
    @(negedge clock);
    stall = st; branch_taken = br; branch_imm = imm; jump = jmp; jump_index = idx;
    jr = j; jr_addr = ja; halt = hl; resume = rs;
    expect_next(e_pc, e_fv, e_h, e_tr, e_epc);
  endtask

  task automatic idle(input logic [31:0] e_pc, input logic [31:0] e_epc);
    step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, e_pc, 1, 0, 0, e_epc);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_fv"}, {31'b0, fetch_valid}, 32'h0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
    chk({tag, "_trap"}, {31'b0, trap}, 32'h0);
    chk({tag, "_epc"}, epc, 32'h0);
    chk({tag, "_pc28"}, {4'b0, pc28}, 32'h0);
  endtask

  // Monitor: after each rising edge, compare both instances against the oldest expectation.
  initial begin
    exp_t        e;
    logic [31:0] e4;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        e4 = e.pc + 32'd4;
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e4);
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.fv});
        chk("halted", {31'b0, halted}, {31'b0, e.h});
        chk("trap", {31'b0, trap}, {31'b0, e.tr});
        chk("epc", epc, e.epc);
        chk("pc28", {4'b0, pc28}, {4'b0, e.pc[27:0]});
        chk("pc_plus4_28", {4'b0, pc_plus4_28}, {4'b0, e4[27:0]});
        chk("trap28", {31'b0, trap28}, {31'b0, e.tr});
        chk("epc28", {4'b0, epc28}, {4'b0, e.epc[27:0]});
        chk("halted28", {31'b0, halted28}, {31'b0, e.h});
        chk("fv28", {31'b0, fetch_valid28}, {31'b0, e.fv});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b1;
    expect_next(32'h0, 1, 0, 0, 32'h0);            // BOOT -> RUN, pc still at reset address
    idle(32'h4, 0);
    idle(32'h8, 0);
    idle(32'hC, 0);
    idle(32'h10, 0);
    // stall beats a simultaneous jump
    step(1, 0, 16'h0, 1, 26'h3FF, 0, 32'h0, 0, 0, 32'h10, 1, 0, 0, 32'h0);
    // halt: this cycle's increment lands, then frozen
    step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1, 0, 32'h14, 0, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 16'h1, 1, 26'h5, 1, 32'h101, 1, 0, 32'h14, 0, 1, 0, 32'h0);
    step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1, 32'h14, 1, 0, 0, 32'h0);
    idle(32'h18, 0);
    step(0, 0, 16'h0, 0, 26'h0, 1, 32'h40, 0, 0, 32'h40, 1, 0, 0, 32'h0);
    // 0x44 + (-4 << 2) = 0x34
    step(0, 1, 16'hFFFC, 0, 26'h0, 0, 32'h0, 0, 0, 32'h34, 1, 0, 0, 32'h0);
    // jump outranks branch: {0x0, 0x10, 00} = 0x40
    step(0, 1, 16'h0100, 1, 26'h10, 0, 32'h0, 0, 0, 32'h40, 1, 0, 0, 32'h0);
    step(0, 0, 16'h0, 0, 26'h0, 1, 32'h20, 0, 0, 32'h20, 1, 0, 0, 32'h0);
    // misaligned jr outranks jump and traps to 0x80
    step(0, 0, 16'h0, 1, 26'h7, 1, 32'h102, 0, 0, 32'h80, 1, 0, 1, 32'h102);
    idle(32'h84, 32'h102);
    // top-of-space target then silent wrap; the 28-bit instance sees 0xFFFFFFC
    step(0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 32'h102);
    idle(32'h0, 32'h102);
    step(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1, 0, 32'h0, 1, 0, 0, 32'h102);
    idle(32'h4, 32'h102);
    step(0, 0, 16'h0, 0, 26'h0, 1, 32'h2C, 0, 0, 32'h2C, 1, 0, 0, 32'h102);
    idle(32'h30, 32'h102);
    // asynchronous reset mid-cycle with a misaligned jr pending
    @(negedge clock);
    jr = 1'b1; jr_addr = 32'h101;
    #2 reset = 1'b0;
    #1 check_reset_state("async_reset");
    @(negedge clock);
    jr = 1'b0; jr_addr = 32'h0;
    reset = 1'b1;
    expect_next(32'h0, 1, 0, 0, 32'h0);
    idle(32'h4, 0);
    repeat (3) @(posedge clock);
    #2;
    chk("scoreboard_drained", q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
